// File: rtl/rr_mux.sv
// M-to-1 arbitrated multiplexer: round-robin or fixed-priority grant feeding
// a one-entry registered output stage with valid/ready handshakes.
module rr_mux #(
  parameter int N     = 32,
  parameter int M     = 32,
  parameter int SEL_W = $clog2(M)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fixed_pri,
  input  logic [M*N-1:0]   in_data,
  input  logic [M-1:0]     in_valid,
  output logic [M-1:0]     in_ready,
  output logic [N-1:0]     out_data,
  output logic [SEL_W-1:0] out_sel,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam logic [SEL_W:0]   M_EXT    = (SEL_W+1)'(M);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(M - 1);

  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [N-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0] out_sel_q, out_sel_d;
  logic             out_valid_q, out_valid_d;

  logic [SEL_W-1:0] start_s;
  logic [SEL_W:0]   sum_s;
  logic [SEL_W:0]   cand_s;
  logic             hit_s;
  logic             win_found_s;
  logic [SEL_W-1:0] win_idx_s;
  logic             load_s;
  logic             xfer_s;
  logic [M-1:0]     in_ready_s;

  // Wrapping scan from the start index; fixed priority is a scan from channel 0.
  always_comb begin
    start_s     = fixed_pri ? '0 : ptr_q;
    win_found_s = 1'b0;
    win_idx_s   = '0;
    sum_s       = '0;
    cand_s      = '0;
    hit_s       = 1'b0;
    for (int i = 0; i < M; i++) begin
      sum_s       = {1'b0, start_s} + (SEL_W+1)'(i);
      cand_s      = (sum_s >= M_EXT) ? (sum_s - M_EXT) : sum_s;
      hit_s       = ~win_found_s & in_valid[cand_s[SEL_W-1:0]];
      win_idx_s   = hit_s ? cand_s[SEL_W-1:0] : win_idx_s;
      win_found_s = win_found_s | hit_s;
    end
  end

  assign load_s = ~out_valid_q | out_ready;
  assign xfer_s = win_found_s & load_s & ~rst;

  // One-hot accept to the winner; reset blocks any grant so nothing transfers.
  always_comb begin
    in_ready_s = '0;
    if (xfer_s) begin
      in_ready_s[win_idx_s] = 1'b1;
    end else begin
      in_ready_s = '0;
    end
  end

  // Output register and pointer next state; in_data only feeds the register.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    ptr_d       = ptr_q;
    if (xfer_s) begin
      out_data_d  = in_data[int'(win_idx_s)*N +: N];
      out_sel_d   = win_idx_s;
      out_valid_d = 1'b1;
      ptr_d       = (win_idx_s == LAST_IDX) ? '0 : (win_idx_s + SEL_W'(1));
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      ptr_q       <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_mux.sv
// Self-checking bench for rr_mux (M=5, N=8): reference arbiter model plus a
// scoreboard of expected output words, and scenario-specific inline checks.
module tb_rr_mux;
  localparam int M  = 5;
  localparam int N  = 8;
  localparam int SW = $clog2(M);

  logic           clk = 1'b0;
  logic           rst;
  logic           fixed_pri;
  logic [M*N-1:0] in_data;
  logic [M-1:0]   in_valid;
  logic [M-1:0]   in_ready;
  logic [N-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           out_valid;
  logic           out_ready;

  typedef struct packed {
    logic [SW-1:0] sel;
    logic [N-1:0]  data;
  } item_t;

  item_t sb_q[$];
  logic  m_valid;
  int    m_ptr;
  int    n_cmp = 0;
  int    n_err = 0;

  always #5 clk = ~clk;

  rr_mux #(.N(N), .M(M)) dut (
    .clk      (clk),
    .rst      (rst),
    .fixed_pri(fixed_pri),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_sel  (out_sel),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  function automatic int model_winner(logic [M-1:0] v, logic fp, int p);
    int start;
    int c;
    start = fp ? 0 : p;
    for (int i = 0; i < M; i++) begin
      c = (start + i) % M;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic set_word(int k, logic [N-1:0] v);
    in_data[k*N +: N] = v;
  endtask

  // One clock: check grant and output against the model, then advance it.
  task automatic drive_cycle();
    int           w;
    logic [M-1:0] exp_rdy;
    item_t        it;
    #1;
    w       = model_winner(in_valid, fixed_pri, m_ptr);
    exp_rdy = '0;
    if (!rst && (!m_valid || out_ready) && w >= 0) exp_rdy[w] = 1'b1;
    n_cmp++;
    if (in_ready !== exp_rdy) begin
      n_err++;
      $display("FAIL in_ready: got %b expected %b at %0t", in_ready, exp_rdy, $time);
    end
    n_cmp++;
    if (out_valid !== m_valid) begin
      n_err++;
      $display("FAIL out_valid: got %b expected %b at %0t", out_valid, m_valid, $time);
    end
    if (m_valid) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_err++;
        $display("FAIL sb_empty: output valid with no expected word at %0t", $time);
      end else begin
        it = sb_q[0];
        if ({out_sel, out_data} !== it) begin
          n_err++;
          $display("FAIL sb_word: got sel %0d data %h expected sel %0d data %h",
                   out_sel, out_data, it.sel, it.data);
        end
        if (out_ready && !rst) void'(sb_q.pop_front());
      end
    end
    if (rst) begin
      sb_q.delete();
      m_valid = 1'b0;
      m_ptr   = 0;
    end else if (exp_rdy != '0) begin
      it.sel  = SW'(w);
      it.data = in_data[w*N +: N];
      sb_q.push_back(it);
      m_valid = 1'b1;
      m_ptr   = (w == M - 1) ? 0 : w + 1;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    drive_cycle();
    rst = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", out_valid); end
    n_cmp++;
    if (out_data !== 8'h00) begin n_err++; $display("FAIL rst_data: got %h expected 00", out_data); end
    n_cmp++;
    if (out_sel !== 3'd0) begin n_err++; $display("FAIL rst_sel: got %0d expected 0", out_sel); end
  endtask

  task automatic test_rr_two();
    int exp_seq[6] = '{1, 3, 1, 3, 1, 3};
    for (int k = 0; k < M; k++) set_word(k, 8'h10 + 8'(k));
    in_valid  = 5'b01010;
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      drive_cycle();
      n_cmp++;
      if (out_sel !== 3'(exp_seq[j]) || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL rr_two[%0d]: got sel %0d valid %b expected sel %0d valid 1",
                 j, out_sel, out_valid, exp_seq[j]);
      end
    end
    in_valid = '0;
    drive_cycle();
  endtask

  task automatic test_rr_all();
    int exp_seq[6] = '{0, 1, 2, 3, 4, 0};
    rst = 1'b1;
    drive_cycle();
    rst = 1'b0;
    for (int k = 0; k < M; k++) set_word(k, 8'h20 + 8'(k));
    in_valid  = 5'b11111;
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      drive_cycle();
      n_cmp++;
      if (out_sel !== 3'(exp_seq[j]) || out_data !== 8'h20 + 8'(exp_seq[j])) begin
        n_err++;
        $display("FAIL rr_all[%0d]: got sel %0d data %h expected sel %0d", j, out_sel, out_data, exp_seq[j]);
      end
    end
    in_valid = '0;
    drive_cycle();
  endtask

  task automatic test_fixed();
    fixed_pri = 1'b1;
    for (int k = 0; k < M; k++) set_word(k, 8'h30 + 8'(k));
    in_valid = 5'b10001;
    for (int j = 0; j < 4; j++) begin
      drive_cycle();
      n_cmp++;
      if (out_sel !== 3'd0) begin n_err++; $display("FAIL fixed_hi[%0d]: got sel %0d expected 0", j, out_sel); end
    end
    in_valid = 5'b10000;
    drive_cycle();
    n_cmp++;
    if (out_sel !== 3'd4) begin n_err++; $display("FAIL fixed_drop: got sel %0d expected 4", out_sel); end
    fixed_pri = 1'b0;
  endtask

  task automatic test_backpressure();
    in_valid = 5'b00100;
    set_word(2, 8'hA5);
    drive_cycle();
    set_word(2, 8'h5A);
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1;
      n_cmp++;
      if (in_ready !== 5'b00000) begin n_err++; $display("FAIL bp_ready[%0d]: got %b expected 00000", j, in_ready); end
      drive_cycle();
      n_cmp++;
      if (out_data !== 8'hA5 || out_sel !== 3'd2 || out_valid !== 1'b1) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got data %h sel %0d valid %b expected a5 2 1", j, out_data, out_sel, out_valid);
      end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 5'b00100) begin n_err++; $display("FAIL bp_release: got %b expected 00100", in_ready); end
    drive_cycle();
    n_cmp++;
    if (out_data !== 8'h5A) begin n_err++; $display("FAIL bp_next: got %h expected 5a", out_data); end
    in_valid = '0;
  endtask

  task automatic test_pop_idle();
    out_ready = 1'b1;
    drive_cycle();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h5A || out_sel !== 3'd2) begin
      n_err++;
      $display("FAIL pop_idle: got valid %b data %h sel %0d expected 0 5a 2", out_valid, out_data, out_sel);
    end
    set_word(4, 8'h4C);
    in_valid = 5'b10000;
    drive_cycle();
    n_cmp++;
    if (out_valid !== 1'b1 || out_sel !== 3'd4 || out_data !== 8'h4C) begin
      n_err++;
      $display("FAIL pop_single: got valid %b sel %0d data %h expected 1 4 4c", out_valid, out_sel, out_data);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int k = 0; k < M; k++) set_word(k, 8'h40 + 8'(k));
    in_valid = 5'b11111;
    drive_cycle();
    rst       = 1'b1;
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 5'b00000) begin n_err++; $display("FAIL rst_mid_ready: got %b expected 00000", in_ready); end
    drive_cycle();
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_sel !== 3'd0) begin
      n_err++;
      $display("FAIL rst_mid_out: got valid %b data %h sel %0d expected 0 00 0", out_valid, out_data, out_sel);
    end
    rst = 1'b0;
    drive_cycle();
    n_cmp++;
    if (out_sel !== 3'd0 || out_data !== 8'h40) begin
      n_err++;
      $display("FAIL rst_restart: got sel %0d data %h expected 0 40", out_sel, out_data);
    end
  endtask

  initial begin
    rst       = 1'b1;
    fixed_pri = 1'b0;
    out_ready = 1'b0;
    in_valid  = '0;
    in_data   = '0;
    m_valid   = 1'b0;
    m_ptr     = 0;
    @(posedge clk);
    #1;
    test_reset();
    test_rr_two();
    test_rr_all();
    test_fixed();
    test_backpressure();
    test_pop_idle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised M-to-1 arbitrated multiplexer with valid/ready handshakes and a registered output stage. It is the next generation of the fixed 32:1 select mux. Channel count and word width are generics. Input selection comes from an internal round-robin or fixed-priority arbiter instead of an external select, and the chosen word is held in an output register until the consumer takes it. It sits between multiple producers (e.g. register-file write sources, peripheral request queues) and a single shared consumer.

## Interface
- N, default 32: data width of every channel, ≥1.
- M, default 32: channel count, ≥2; need not be a power of two.
- SEL_W, default $clog2(M): width of channel index; derived, not overridden.

- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- fixed_pri  input  1  0 = round-robin, 1 = fixed priority (channel 0 highest); sampled each cycle.
- in_data  input  M*N  flattened channel words; channel k occupies [k*N +: N].
- in_valid  input  M  per-channel request.
- in_ready  output  M  per-channel accept; at most one bit high.
- out_data  output  N  registered selected word.
- out_sel  output  SEL_W  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts out_data this cycle.

## Operation
- Output register is one entry deep. load = ~out_valid | out_ready.
- Grant search:
  - Round-robin: start at ptr and scan ptr, ptr+1, … M-1, 0, … ptr-1. The first channel with in_valid high is the winner.
  - Fixed priority: the lowest-index valid channel is the winner.
- in_ready[w] = load & in_valid[w] for winner w; all other bits are 0. No winner means in_ready = 0.
- Transfer on channel k when in_valid[k] & in_ready[k]. On the next edge:
  - out_data ← in_data[k].
  - out_sel ← k.
  - out_valid ← 1.
  - ptr ← (k == M-1) ? 0 : k+1.
- ptr updates only on a transfer, in both modes. Switching fixed_pri does not reset ptr.
- Pop (out_valid & out_ready) with no transfer in the same cycle: out_valid ← 0. out_data and out_sel keep their last values.
- Pop and transfer in the same cycle: the register reloads with the new word and out_valid stays 1.
- out_valid & ~out_ready: out_data, out_sel and out_valid are held stable and in_ready = 0.
- Producers hold in_valid and in_data until their handshake. Deasserting in_valid without a handshake is permitted and simply removes that channel from the search.
- ptr is never ≥ M. Wrap arithmetic is explicit and does not rely on power-of-two overflow.

## Timing
- Reset (rst high at an edge):
  - out_valid = 0, out_data = 0, out_sel = 0, ptr = 0.
  - in_ready is forced to 0 while rst is high.
- Reset mid-operation discards any held word. A producer being granted in that cycle sees in_ready = 0, so no transfer occurs.
- Latency: input handshake at edge t gives out_valid = 1 with the data after edge t (visible in cycle t+1).
- Throughput: one word per cycle when out_ready is held high.
- in_ready depends combinationally on in_valid, out_valid, out_ready, fixed_pri, rst and ptr. It has no path from in_data.
- out_data, out_sel and out_valid are purely registered, with no combinational input-to-output path.
- A fully loaded round-robin arbiter (all M valid) grants each channel exactly once per M consecutive transfers.

## Test plan
- Reset, then M=5, N=8, round-robin. Channels 1 and 3 valid continuously, out_ready=1 → grants 1,3,1,3… (out_sel alternates), one word per cycle, out_valid first high one cycle after first handshake.
- M=5, all channels valid, round-robin, out_ready=1 → out_sel sequence 0,1,2,3,4,0 (wrap at non-power-of-two); each in_ready one-hot.
- fixed_pri=1, channels 0 and 4 valid continuously → out_sel stays 0 on every transfer. Drop channel 0 → out_sel = 4 the next cycle.
- Backpressure: out_ready=0 for 3 cycles with word 0xA5 from channel 2 held → out_data=0xA5, out_sel=2, out_valid=1 stable and in_ready=0 for all 3 cycles. Raising out_ready → the next word loads in the same cycle (no bubble).
- Pop with no requesters → out_valid falls to 0 and out_data retains its value. A later single request on channel 4 → out_sel=4 after one cycle.
- Assert rst while out_valid=1 and a grant is pending → all outputs are at reset values the next cycle and no in_ready is seen. After release, round-robin restarts from channel 0.
